// File: rtl/cv32e40p_pkg.sv
// Shared types and constants for the Winograd F(2x2,3x3) tile scheduler.
// Optional ReLU on write-back is enabled by defining CNN_TILE_SCHED_RELU_EN.
package cv32e40p_pkg;

  localparam int TILE_WORDS = 16;
  localparam int OUT_WORDS  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAL,
    S_WAIT,
    S_WR,
    S_DONE
  } tile_state_e;

  // Reference form of the read address; the datapath builds it incrementally.
  function automatic logic [31:0] tile_rd_addr(
    input logic [31:0] base,
    input logic [31:0] stride,
    input logic [3:0]  k
  );
    logic [31:0] ofs;
    ofs = 32'(k[3:2]) * stride + 32'(k[1:0]);
    return base + (ofs << 2);
  endfunction

endpackage

// File: rtl/cv32e40p_cnn_tile_sched_if.sv
// Core, memory and datapath signals of the tile scheduler.
// relu_i exists only when CNN_TILE_SCHED_RELU_EN is defined.
interface cv32e40p_cnn_tile_sched_if #(
  parameter int STRIDE_W = 16
);
  logic                start_i;
  logic [31:0]         in_base_i;
  logic [31:0]         out_base_i;
  logic [STRIDE_W-1:0] row_stride_i;
`ifdef CNN_TILE_SCHED_RELU_EN
  logic                relu_i;
`endif
  logic                busy_o;
  logic                done_o;
  logic                mem_req_o;
  logic                mem_we_o;
  logic [31:0]         mem_addr_o;
  logic [31:0]         mem_wdata_o;
  logic                mem_gnt_i;
  logic                mem_rvalid_i;
  logic [31:0]         mem_rdata_i;
  logic                dp_load_o;
  logic [3:0]          dp_idx_o;
  logic [31:0]         dp_data_o;
  logic                dp_cal_o;
  logic [31:0]         y0_i;
  logic [31:0]         y1_i;
  logic [31:0]         y2_i;
  logic [31:0]         y3_i;

  modport master (
    input  start_i,
    input  in_base_i,
    input  out_base_i,
    input  row_stride_i,
`ifdef CNN_TILE_SCHED_RELU_EN
    input  relu_i,
`endif
    output busy_o,
    output done_o,
    output mem_req_o,
    output mem_we_o,
    output mem_addr_o,
    output mem_wdata_o,
    input  mem_gnt_i,
    input  mem_rvalid_i,
    input  mem_rdata_i,
    output dp_load_o,
    output dp_idx_o,
    output dp_data_o,
    output dp_cal_o,
    input  y0_i,
    input  y1_i,
    input  y2_i,
    input  y3_i
  );

  modport slave (
    output start_i,
    output in_base_i,
    output out_base_i,
    output row_stride_i,
`ifdef CNN_TILE_SCHED_RELU_EN
    output relu_i,
`endif
    input  busy_o,
    input  done_o,
    input  mem_req_o,
    input  mem_we_o,
    input  mem_addr_o,
    input  mem_wdata_o,
    output mem_gnt_i,
    output mem_rvalid_i,
    output mem_rdata_i,
    input  dp_load_o,
    input  dp_idx_o,
    input  dp_data_o,
    input  dp_cal_o,
    output y0_i,
    output y1_i,
    output y2_i,
    output y3_i
  );
endinterface

// File: rtl/cv32e40p_cnn_tile_addr_gen.sv
// Incremental 4x4 tile read-address generator: +4 per column,
// +stride*4 per row, so no multiplier is needed.
module cv32e40p_cnn_tile_addr_gen #(
  parameter int STRIDE_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                init_i,
  input  logic                adv_i,
  input  logic [31:0]         base_i,
  input  logic [STRIDE_W-1:0] stride_i,
  output logic [31:0]         addr_o
);

  logic [31:0] addr_q, addr_d;
  logic [31:0] row_q, row_d;
  logic [31:0] step_q, step_d;
  logic [1:0]  col_q, col_d;

  always_comb begin
    addr_d = addr_q;
    row_d  = row_q;
    step_d = step_q;
    col_d  = col_q;
    if (init_i) begin
      addr_d = base_i;
      row_d  = base_i;
      step_d = 32'(stride_i) << 2;
      col_d  = '0;
    end else if (adv_i) begin
      if (col_q == 2'd3) begin
        row_d  = row_q + step_q;
        addr_d = row_q + step_q;
        col_d  = '0;
      end else begin
        addr_d = addr_q + 32'd4;
        col_d  = col_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      row_q  <= '0;
      step_q <= '0;
      col_q  <= '0;
    end else begin
      addr_q <= addr_d;
      row_q  <= row_d;
      step_q <= step_d;
      col_q  <= col_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/cv32e40p_cnn_tile_sched.sv
// Winograd F(2x2,3x3) tile sequencer: load 4x4 tile, fire datapath,
// write 2x2 results. Define CNN_TILE_SCHED_RELU_EN for optional ReLU.
module cv32e40p_cnn_tile_sched
  import cv32e40p_pkg::*;
#(
  parameter int CAL_LAT  = 4,
  parameter int STRIDE_W = 16
) (
  input logic clk,
  input logic rst,
  cv32e40p_cnn_tile_sched_if.master bus
);

  tile_state_e state_q, state_d;
  logic [4:0]  iss_q, iss_d;
  logic [4:0]  rcv_q, rcv_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [1:0]  wr_q, wr_d;
  logic [31:0] obase_q, obase_d;
  logic [3:0][31:0] res_q, res_d;
  logic [31:0] res_sel, wr_data, rd_addr;
  logic        accept, adv;

`ifdef CNN_TILE_SCHED_RELU_EN
  logic relu_q, relu_d;
`endif

  assign accept = (state_q == S_IDLE) && bus.start_i;
  assign adv = (state_q == S_RD) && !iss_q[4] && bus.mem_gnt_i;

  cv32e40p_cnn_tile_addr_gen #(
    .STRIDE_W(STRIDE_W)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .init_i  (accept),
    .adv_i   (adv),
    .base_i  (bus.in_base_i),
    .stride_i(bus.row_stride_i),
    .addr_o  (rd_addr)
  );

  always_comb begin
    res_sel = res_q[wr_q];
`ifdef CNN_TILE_SCHED_RELU_EN
    wr_data = (relu_q && res_sel[31]) ? '0 : res_sel;
`else
    wr_data = res_sel;
`endif
  end

  always_comb begin
    state_d = state_q;
    iss_d   = iss_q;
    rcv_d   = rcv_q;
    wcnt_d  = wcnt_q;
    wr_d    = wr_q;
    obase_d = obase_q;
    res_d   = res_q;
`ifdef CNN_TILE_SCHED_RELU_EN
    relu_d  = relu_q;
`endif
    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    bus.dp_load_o   = 1'b0;
    bus.dp_idx_o    = '0;
    bus.dp_data_o   = '0;
    bus.dp_cal_o    = 1'b0;
    bus.done_o      = 1'b0;
    bus.busy_o      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          state_d = S_RD;
          iss_d   = '0;
          rcv_d   = '0;
          wcnt_d  = '0;
          wr_d    = '0;
          obase_d = bus.out_base_i;
`ifdef CNN_TILE_SCHED_RELU_EN
          relu_d  = bus.relu_i;
`endif
        end
      end
      S_RD: begin
        bus.busy_o = 1'b1;
        if (!iss_q[4]) begin
          bus.mem_req_o  = 1'b1;
          bus.mem_addr_o = rd_addr;
        end
        if (adv) iss_d = iss_q + 5'd1;
        // Responses may trail issues; late extras are dropped.
        if (bus.mem_rvalid_i && !rcv_q[4]) begin
          bus.dp_load_o = 1'b1;
          bus.dp_idx_o  = rcv_q[3:0];
          bus.dp_data_o = bus.mem_rdata_i;
          rcv_d = rcv_q + 5'd1;
        end
        if (iss_d == 5'(TILE_WORDS) && rcv_d == 5'(TILE_WORDS)) begin
          state_d = S_CAL;
        end
      end
      S_CAL: begin
        bus.busy_o   = 1'b1;
        bus.dp_cal_o = 1'b1;
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        bus.busy_o = 1'b1;
        if (wcnt_q == 4'(CAL_LAT - 1)) begin
          res_d   = {bus.y3_i, bus.y2_i, bus.y1_i, bus.y0_i};
          state_d = S_WR;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      S_WR: begin
        bus.busy_o      = 1'b1;
        bus.mem_req_o   = 1'b1;
        bus.mem_we_o    = 1'b1;
        bus.mem_addr_o  = obase_q + {28'd0, wr_q, 2'b00};
        bus.mem_wdata_o = wr_data;
        if (bus.mem_gnt_i) begin
          wr_d = wr_q + 2'd1;
          if (wr_q == 2'(OUT_WORDS - 1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        bus.done_o = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      iss_q   <= '0;
      rcv_q   <= '0;
      wcnt_q  <= '0;
      wr_q    <= '0;
      obase_q <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      iss_q   <= iss_d;
      rcv_q   <= rcv_d;
      wcnt_q  <= wcnt_d;
      wr_q    <= wr_d;
      obase_q <= obase_d;
      res_q   <= res_d;
    end
  end

`ifdef CNN_TILE_SCHED_RELU_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) relu_q <= 1'b0;
    else     relu_q <= relu_d;
  end
`endif

endmodule

// File: tb/tb_cv32e40p_cnn_tile_sched.sv
// Randomized bench for cv32e40p_cnn_tile_sched with a timeline model
// of the tile (issue/response/write counts) checked every cycle.
module tb_cv32e40p_cnn_tile_sched;
  localparam int CAL_LAT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cv32e40p_cnn_tile_sched_if #(.STRIDE_W(16)) bus ();

  cv32e40p_cnn_tile_sched #(
    .CAL_LAT (CAL_LAT),
    .STRIDE_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // model of the running tile
  bit active = 0;
  int c = 0, nrd = 0, nld = 0, nwr = 0;
  int cal_cyc = -1, done_cyc = -1, stall = 0;
  int tiles_done = 0, accepts = 0;
  logic [31:0] m_in, m_out;
  logic [15:0] m_str;
  bit m_relu;
  logic [31:0] m_y[4];
  logic [31:0] tile_y[4];
  logic [31:0] obs_rd[16];
  logic [31:0] obs_wr[4];
  logic [31:0] pend[$];
  int gnt_mode = 0, rv_pct = 100;
  bit gnt_tog = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E3779B1 + 32'h1234_5678;
  endfunction

  function automatic logic [31:0] exp_rd(input int k);
    logic [31:0] ofs;
    ofs = 32'(k / 4) * {16'd0, m_str} + 32'(k % 4);
    return m_in + (ofs << 2);
  endfunction

  function automatic logic [31:0] relu_f(input logic [31:0] v, input bit en);
    return (en && v[31]) ? 32'd0 : v;
  endfunction

  // compare process
  always @(negedge clk) begin : cmp
    bit idle_now, rd_e, wr_e, ld_e, cal_e, dn_e, bz_e;
    if (rst) begin
      chk("rst_ctl", {26'd0, bus.busy_o, bus.done_o, bus.mem_req_o,
          bus.mem_we_o, bus.dp_load_o, bus.dp_cal_o}, 32'd0);
      chk("rst_addr", bus.mem_addr_o | bus.mem_wdata_o, 32'd0);
      chk("rst_dp", bus.dp_data_o | {28'd0, bus.dp_idx_o}, 32'd0);
      active = 0;
      cal_cyc = -1;
      done_cyc = -1;
      pend.delete();
    end else begin
      idle_now = !active;
      if (active) c++;
      rd_e  = active && nrd < 16;
      wr_e  = active && cal_cyc >= 0 && c > cal_cyc + CAL_LAT && nwr < 4;
      ld_e  = active && bus.mem_rvalid_i && nld < 16;
      cal_e = active && cal_cyc == c;
      dn_e  = active && done_cyc >= 0 && c == done_cyc;
      bz_e  = active && !dn_e;
      chk("ctl", {26'd0, bus.busy_o, bus.done_o, bus.mem_req_o,
          bus.mem_we_o, bus.dp_load_o, bus.dp_cal_o},
          {26'd0, bz_e, dn_e, rd_e | wr_e, wr_e, ld_e, cal_e});
      if (rd_e) chk("rd_addr", bus.mem_addr_o, exp_rd(nrd));
      if (wr_e) begin
        chk("wr_addr", bus.mem_addr_o, m_out + 32'(nwr * 4));
        chk("wr_data", bus.mem_wdata_o, relu_f(m_y[nwr], m_relu));
      end
      if (ld_e) begin
        chk("ld_idx", {28'd0, bus.dp_idx_o}, 32'(nld));
        chk("ld_data", bus.dp_data_o, mem_word(exp_rd(nld)));
      end
      if (bus.mem_req_o && !bus.mem_we_o && bus.mem_gnt_i)
        pend.push_back(mem_word(bus.mem_addr_o));
      if ((rd_e || wr_e) && !bus.mem_gnt_i) stall++;
      if (rd_e && bus.mem_gnt_i) begin
        obs_rd[nrd] = bus.mem_addr_o;
        nrd++;
      end
      if (ld_e) begin
        nld++;
        if (nld == 16) cal_cyc = c + 1;
      end
      if (wr_e && bus.mem_gnt_i) begin
        obs_wr[nwr] = bus.mem_wdata_o;
        nwr++;
        if (nwr == 4) done_cyc = c + 1;
      end
      if (dn_e) begin
        active = 0;
        tiles_done++;
      end
      if (idle_now && bus.start_i) begin
        active = 1;
        accepts++;
        c = 0; nrd = 0; nld = 0; nwr = 0; stall = 0;
        cal_cyc = -1;
        done_cyc = -1;
        m_in = bus.in_base_i;
        m_out = bus.out_base_i;
        m_str = bus.row_stride_i;
`ifdef CNN_TILE_SCHED_RELU_EN
        m_relu = bus.relu_i;
`else
        m_relu = 0;
`endif
        for (int i = 0; i < 4; i++) m_y[i] = tile_y[i];
      end
    end
  end

  // memory and datapath responder
  always @(posedge clk) begin
    #1;
    case (gnt_mode)
      0: bus.mem_gnt_i = 1'b1;
      1: begin
        gnt_tog = !gnt_tog;
        bus.mem_gnt_i = gnt_tog;
      end
      default: bus.mem_gnt_i = ($urandom_range(99) < 60);
    endcase
    if (!rst && pend.size() > 0 && $urandom_range(99) < rv_pct) begin
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i = pend.pop_front();
    end else begin
      bus.mem_rvalid_i = 1'b0;
      bus.mem_rdata_i = $urandom;
    end
    if (active && cal_cyc >= 0 && c + 1 == cal_cyc + CAL_LAT) begin
      bus.y0_i = m_y[0]; bus.y1_i = m_y[1];
      bus.y2_i = m_y[2]; bus.y3_i = m_y[3];
    end else begin
      bus.y0_i = $urandom; bus.y1_i = $urandom;
      bus.y2_i = $urandom; bus.y3_i = $urandom;
    end
  end

  task automatic set_cfg(input logic [31:0] ib, input logic [31:0] ob,
                         input logic [15:0] st, input bit rl);
    bus.in_base_i = ib;
    bus.out_base_i = ob;
    bus.row_stride_i = st;
`ifdef CNN_TILE_SCHED_RELU_EN
    bus.relu_i = rl;
`else
    if (rl) begin end
`endif
  endtask

  task automatic wait_tile();
    int t0;
    t0 = tiles_done;
    for (int i = 0; i < 600 && tiles_done == t0; i++) @(posedge clk);
    #1;
    chk("tile_done", 32'(tiles_done - t0), 32'd1);
  endtask

  task automatic run_tile(input logic [31:0] ib, input logic [31:0] ob,
                          input logic [15:0] st, input bit rl,
                          input logic [31:0] y0, input logic [31:0] y1,
                          input logic [31:0] y2, input logic [31:0] y3);
    @(posedge clk); #1;
    tile_y[0] = y0; tile_y[1] = y1; tile_y[2] = y2; tile_y[3] = y3;
    set_cfg(ib, ob, st, rl);
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    set_cfg($urandom, $urandom, 16'($urandom), 1'b1);
    wait_tile();
  endtask

  initial begin
    int a0, t0;
    bit hit;
    rst = 1'b1;
    bus.start_i = 1'b0;
    set_cfg(0, 0, 0, 0);
    bus.mem_gnt_i = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i = '0;
    bus.y0_i = '0; bus.y1_i = '0; bus.y2_i = '0; bus.y3_i = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // zero-wait memory, literal timeline and addresses
    gnt_mode = 0; rv_pct = 100;
    run_tile(32'h1000, 32'h2000, 16'd8, 1'b0,
             32'd5, 32'hFFFFFFFD, 32'h7FFFFFFF, 32'hFFFFFFFF);
    chk("done_cycle", 32'(done_cyc), 32'd27);
    chk("stall0", 32'(stall), 32'd0);
    chk("rd0", obs_rd[0], 32'h1000);
    chk("rd3", obs_rd[3], 32'h100C);
    chk("rd4", obs_rd[4], 32'h1020);
    chk("rd15", obs_rd[15], 32'h106C);
    chk("wr0", obs_wr[0], 32'd5);
    chk("wr1", obs_wr[1], 32'hFFFFFFFD);
    chk("wr2", obs_wr[2], 32'h7FFFFFFF);
    chk("wr3", obs_wr[3], 32'hFFFFFFFF);

`ifdef CNN_TILE_SCHED_RELU_EN
    run_tile(32'h1000, 32'h2000, 16'd8, 1'b1,
             32'd5, 32'hFFFFFFFD, 32'h7FFFFFFF, 32'hFFFFFFFF);
    chk("relu0", obs_wr[0], 32'd5);
    chk("relu1", obs_wr[1], 32'd0);
    chk("relu2", obs_wr[2], 32'h7FFFFFFF);
    chk("relu3", obs_wr[3], 32'd0);
`endif

    // grant every other cycle
    gnt_mode = 1;
    run_tile(32'h4000, 32'h5000, 16'd20, 1'b0,
             $urandom, $urandom, $urandom, $urandom);
    chk("stalls_seen", 32'(stall > 0), 32'd1);
    chk("done_delay", 32'(done_cyc), 32'(27 + stall));

    // address wrap-around
    gnt_mode = 0;
    run_tile(32'hFFFFFFF0, 32'h0, 16'd1, 1'b0,
             $urandom, $urandom, $urandom, $urandom);
    chk("wrap0", obs_rd[0], 32'hFFFFFFF0);
    chk("wrap7", obs_rd[7], 32'h0);
    chk("wrap15", obs_rd[15], 32'h8);

    // start held high, then back-to-back start after done
    a0 = accepts;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) tile_y[i] = $urandom;
    set_cfg(32'h800, 32'h900, 16'd5, 1'b0);
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) tile_y[i] = $urandom;
    set_cfg(32'h3000, 32'h3100, 16'd3, 1'b0);
    wait_tile();
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    wait_tile();
    chk("accepts", 32'(accepts - a0), 32'd2);

    // randomized tiles
    for (int t = 0; t < 6; t++) begin
      gnt_mode = 2;
      rv_pct = 30 + 10 * t;
      run_tile($urandom & 32'hFFFFFFFC, $urandom & 32'hFFFFFFFC,
               16'($urandom), 1'($urandom),
               $urandom, $urandom, $urandom, $urandom);
    end

    // reset in WAIT
    gnt_mode = 0; rv_pct = 100;
    t0 = tiles_done;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) tile_y[i] = $urandom;
    set_cfg(32'h6000, 32'h7000, 16'd4, 1'b0);
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(posedge clk); #1;
      if (active && cal_cyc >= 0 && c + 1 == cal_cyc + 2) hit = 1;
    end
    chk("reach_wait", 32'(hit), 32'd1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (CAL_LAT + 8) @(posedge clk);
    #1;
    chk("no_done_after_rst", 32'(tiles_done - t0), 32'd0);
    run_tile(32'h6000, 32'h7000, 16'd4, 1'b0,
             32'd1, 32'd2, 32'd3, 32'd4);
    chk("post_rst_wr3", obs_wr[3], 32'd4);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/cv32e40p_cnn_tile_sched.md
# cv32e40p_cnn_tile_sched

Sequencer for the Winograd F(2x2,3x3) convolution datapath in the EX-stage accelerator. On one start command it:
- fetches a 4x4 input tile from data memory, row by row, into the datapath's 16-entry input buffer;
- fires the compute pipeline and waits its fixed latency;
- writes the four 2x2 outputs back to memory, with optional ReLU.

It replaces the per-word software load loop and gives the core one start/done pair per tile.

## Interface
Parameters:
- CAL_LAT, 4, cycles from dp_cal_o pulse to y0_i..y3_i valid (legal range 1..15)
- STRIDE_W, 16, width of the row-stride field in words

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start_i  in  1  start one tile; sampled only in IDLE
- in_base_i  in  32  byte address of tile element (0,0); word aligned
- out_base_i  in  32  byte address of output y0; outputs are consecutive words
- row_stride_i  in  STRIDE_W  feature-map row pitch in words
- busy_o  out  1  high from the cycle after an accepted start until done_o
- done_o  out  1  one-cycle pulse when the last write is granted
- mem_req_o  out  1  memory request
- mem_we_o  out  1  1 = write
- mem_addr_o  out  32  byte address
- mem_wdata_o  out  32  write data
- mem_gnt_i  in  1  request accepted this cycle
- mem_rvalid_i  in  1  read data valid; responses arrive in order, at least 1 cycle after gnt
- mem_rdata_i  in  32  read data
- dp_load_o  out  1  write dp_data_o into datapath buffer entry dp_idx_o
- dp_idx_o  out  4  buffer index 0..15, row-major
- dp_data_o  out  32  buffer write data
- dp_cal_o  out  1  one-cycle compute trigger
- y0_i, y1_i, y2_i, y3_i  in  32 each  signed datapath results

## Operation
- States and transitions:
  - IDLE → RD on start_i.
  - RD → CAL when issued==16 and received==16.
  - CAL → WAIT.
  - WAIT → WR when the wait counter reaches CAL_LAT.
  - WR → DONE when the 4th write is granted.
  - DONE → IDLE.
- Accepting a start latches in_base_i, out_base_i and row_stride_i. Input changes during busy have no effect. start_i outside IDLE is ignored.
- RD, issue side:
  - Issue counter k = 0..15 (r = k[3:2], c = k[1:0]).
  - Read address = in_base + ((r*stride + c) << 2); 32-bit wrap-around, no overflow detection.
  - mem_req_o=1 and mem_we_o=0 while k<16. k advances only on mem_gnt_i.
- RD, response side:
  - A separate response counter counts mem_rvalid_i.
  - Each response drives dp_load_o=1 in the same cycle, with dp_idx_o = response count and dp_data_o = mem_rdata_i.
  - An rvalid after 16 received responses is ignored.
- CAL: dp_cal_o=1 for exactly one cycle. WAIT then counts CAL_LAT cycles. y0_i..y3_i are registered into the result regs on the last WAIT cycle.
- WR, write j = 0..3:
  - mem_req_o=1, mem_we_o=1, mem_addr_o = out_base + (j<<2), mem_wdata_o = result j (ReLU applied if enabled).
  - j advances on mem_gnt_i. The request is held stable until granted.
- Reset values: all outputs 0; state IDLE; counters and latched config 0.
- Reset mid-operation: return to IDLE immediately; no done_o. The memory side is reset together with this block, so no stale rvalid is expected.
- Simultaneous gnt and rvalid in the same RD cycle: both counters advance.

## Timing
- Zero-wait memory (gnt always 1, rvalid one cycle after gnt), start sampled at edge 0:
  - requests in cycles 1–16, loads in cycles 2–17
  - dp_cal_o in cycle 18
  - WAIT cycles 19..18+CAL_LAT
  - writes in cycles 19+CAL_LAT..22+CAL_LAT
  - done_o in 23+CAL_LAT (27 for default CAL_LAT=4)
- Every cycle without mem_gnt_i while requesting extends the phase by one cycle.
- busy_o is low in the done_o cycle. A start in the cycle after done_o is accepted.

## Configuration
- CNN_TILE_SCHED_RELU_EN defined:
  - Adds input port relu_i (1 bit), latched at start.
  - When the latched value is 1, negative results (bit 31 set) are written as 0.
- Undefined: the port is absent and results are written unmodified.

## Structure
- cv32e40p_pkg holds:
  - the state enum type
  - TILE_WORDS=16 and OUT_WORDS=4
  - the address-generation function (base, stride, k)
- Sub-module cv32e40p_cnn_tile_addr_gen: registered row/column counters producing the read address incrementally (+4 per column, +stride*4 per row), avoiding a multiplier.

## Test plan
- Zero-wait memory: in_base=0x1000, stride=8, CAL_LAT=4:
  - read addresses 0x1000, 0x1004, 0x1008, 0x100C, then 0x1020.., last 0x106C
  - dp_idx_o 0..15 in order
  - done_o in cycle 27
- gnt low on every other cycle:
  - all 16 loads correct
  - each mem_addr_o held until granted
  - done_o delayed by exactly the number of ungranted request cycles
- Results y0..y3 = 5, −3, 0x7FFFFFFF, −1, out_base=0x2000:
  - writes to 0x2000/4/8/C with those values
  - with CNN_TILE_SCHED_RELU_EN and relu_i=1: 5, 0, 0x7FFFFFFF, 0
- start_i held high for the whole operation: exactly one tile processed. A second start one cycle after done_o is accepted.
- rst asserted in WAIT: all outputs 0 next cycle, no done_o, no dp_cal_o. A new start then runs a full tile correctly.
- in_base=0xFFFFFFF0, stride=1: addresses wrap to 0x00000000 without error.
